// File: rtl/sram_test_driver.sv
// Write-then-read SRAM pattern tester: one request per address, read-back compare, error capture.
// Optional second inverted-pattern write/read pass when SRAM_TEST_INV_PASS_EN is defined.
module sram_test_driver #(
  parameter int ADDR_W     = 21,
  parameter int DATA_W     = 8,
  parameter int WR_WAIT    = 3,
  parameter int RD_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [ADDR_W-1:0] addr_first,
  input  logic [ADDR_W-1:0] addr_last,
  output logic              mem_start,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rd_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_act
);

  typedef enum logic [2:0] {S_IDLE, S_W_REQ, S_W_WAIT, S_R_REQ, S_R_WAIT, S_R_CHK, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, first_q, first_d, last_q, last_d;
  logic [DATA_W-1:0] seed_q, seed_d, rdata_q, rdata_d;
  logic              mode_q, mode_d, inv_q, inv_d, rd_to_q, rd_to_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, fa_q, fa_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, fe_q, fe_d, fact_q, fact_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d, timeout_q, timeout_d;
  logic [15:0]       err_q, err_d;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] exp_w;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a, input logic md,
                                                input logic [DATA_W-1:0] sd, input logic iv);
    logic [DATA_W-1:0] p;
    p = md ? sd : (a[DATA_W-1:0] ^ sd);
    return iv ? ~p : p;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;     addr_q <= '0;    first_q <= '0;   last_q <= '0;
      seed_q <= '0;          rdata_q <= '0;   mode_q <= 1'b0;  inv_q <= 1'b0;
      rd_to_q <= 1'b0;       cnt_q <= '0;     mem_addr_q <= '0; mem_wdata_q <= '0;
      busy_q <= 1'b0;        done_q <= 1'b0;  pass_q <= 1'b0;  timeout_q <= 1'b0;
      err_q <= '0;           fa_q <= '0;      fe_q <= '0;      fact_q <= '0;
    end else begin
      state_q <= state_d;    addr_q <= addr_d;   first_q <= first_d; last_q <= last_d;
      seed_q <= seed_d;      rdata_q <= rdata_d; mode_q <= mode_d;   inv_q <= inv_d;
      rd_to_q <= rd_to_d;    cnt_q <= cnt_d;     mem_addr_q <= mem_addr_d; mem_wdata_q <= mem_wdata_d;
      busy_q <= busy_d;      done_q <= done_d;   pass_q <= pass_d;   timeout_q <= timeout_d;
      err_q <= err_d;        fa_q <= fa_d;       fe_q <= fe_d;       fact_q <= fact_d;
    end
  end

  always_comb begin
    state_d = state_q;  addr_d = addr_q;   first_d = first_q;  last_d = last_q;
    seed_d = seed_q;    rdata_d = rdata_q; mode_d = mode_q;    inv_d = inv_q;
    rd_to_d = rd_to_q;  cnt_d = cnt_q;     mem_addr_d = mem_addr_q; mem_wdata_d = mem_wdata_q;
    busy_d = busy_q;    done_d = done_q;   pass_d = pass_q;    timeout_d = timeout_q;
    err_d = err_q;      fa_d = fa_q;       fe_d = fe_q;        fact_d = fact_q;
    nxt_addr = addr_q + 1'b1;
    exp_w = pattern(addr_q, mode_q, seed_q, inv_q);
    unique case (state_q)
      S_IDLE: if (start) begin
        seed_d = seed; mode_d = mode; first_d = addr_first; last_d = addr_last; inv_d = 1'b0;
        err_d = '0; fa_d = '0; fe_d = '0; fact_d = '0; timeout_d = 1'b0;
        busy_d = 1'b1; done_d = 1'b0; pass_d = 1'b0;
        if (addr_first > addr_last) begin
          state_d = S_DONE;
        end else begin
          addr_d = addr_first; mem_addr_d = addr_first;
          mem_wdata_d = pattern(addr_first, mode, seed, 1'b0);
          state_d = S_W_REQ;
        end
      end
      S_W_REQ: if (stop) state_d = S_DONE;
               else begin cnt_d = '0; state_d = S_W_WAIT; end
      S_W_WAIT: if (cnt_q == 8'(WR_WAIT - 1)) begin
        if (addr_q == last_q) begin
          addr_d = first_q; mem_addr_d = first_q; state_d = S_R_REQ;
        end else begin
          addr_d = nxt_addr; mem_addr_d = nxt_addr;
          mem_wdata_d = pattern(nxt_addr, mode_q, seed_q, inv_q);
          state_d = S_W_REQ;
        end
      end else cnt_d = cnt_q + 8'd1;
      S_R_REQ: if (stop) state_d = S_DONE;
               else begin cnt_d = '0; rd_to_d = 1'b0; state_d = S_R_WAIT; end
      S_R_WAIT: if (mem_rd_ready) begin
        rdata_d = mem_rdata; state_d = S_R_CHK;
      end else if (cnt_q == 8'(RD_TIMEOUT - 1)) begin
        rd_to_d = 1'b1; timeout_d = 1'b1; rdata_d = '0; state_d = S_R_CHK;
      end else cnt_d = cnt_q + 8'd1;
      S_R_CHK: begin
        // A timed-out read counts as one error; its data is not compared.
        if (rd_to_q || (rdata_q != exp_w)) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          if (err_q == 16'd0) begin fa_d = addr_q; fe_d = exp_w; fact_d = rdata_q; end
        end
        if (addr_q == last_q) begin
`ifdef SRAM_TEST_INV_PASS_EN
          if (!inv_q) begin
            inv_d = 1'b1; addr_d = first_q; mem_addr_d = first_q;
            mem_wdata_d = pattern(first_q, mode_q, seed_q, 1'b1);
            state_d = S_W_REQ;
          end else state_d = S_DONE;
`else
          state_d = S_DONE;
`endif
        end else begin
          addr_d = nxt_addr; mem_addr_d = nxt_addr; state_d = S_R_REQ;
        end
      end
      S_DONE: begin
        busy_d = 1'b0; done_d = 1'b1;
        pass_d = (err_q == 16'd0) && !timeout_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_start = ((state_q == S_W_REQ) || (state_q == S_R_REQ)) && !stop;
    mem_rw    = (state_q == S_R_REQ);
  end

  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign err_count      = err_q;
  assign first_err_addr = fa_q;
  assign first_err_exp  = fe_q;
  assign first_err_act  = fact_q;

endmodule

// File: tb/tb_sram_test_driver.sv
// Scoreboard bench: expected requests/results queued by stimulus, popped by a negedge monitor.
module tb_sram_test_driver;
  localparam int AW = 21;
  localparam int DW = 8;
`ifdef SRAM_TEST_INV_PASS_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1, start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [DW-1:0] seed = '0;
  logic [AW-1:0] addr_first = '0, addr_last = '0;
  logic          mem_start, mem_rw, mem_rd_ready;
  logic [AW-1:0] mem_addr, first_err_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, first_err_exp, first_err_act;
  logic          busy, done, pass, timeout;
  logic [15:0]   err_count;

  sram_test_driver dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode), .seed(seed),
    .addr_first(addr_first), .addr_last(addr_last),
    .mem_start(mem_start), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rd_ready(mem_rd_ready),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
    .first_err_addr(first_err_addr), .first_err_exp(first_err_exp), .first_err_act(first_err_act)
  );

  typedef struct { logic rw; logic [AW-1:0] addr; logic [DW-1:0] wd; } req_t;
  typedef struct {
    logic pass; logic tmo; logic [15:0] err; logic chkf;
    logic [AW-1:0] fa; logic [DW-1:0] fe; logic [DW-1:0] fact; int dcyc;
  } res_t;

  req_t req_q[$];
  res_t res_q[$];
  int   vectors = 0, miscompares = 0, cyc = 0;
  logic rst_s = 1'b1;
  logic stuck3 = 1'b0, noready = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= reset;
  end

  // SRAM model: read data returned two edges after the request, optional stuck bit / no response.
  logic [DW-1:0] mem [int];
  logic          rd_v1;
  logic [DW-1:0] rd_d1;
  always @(posedge clk) begin
    if (reset) begin
      rd_v1 <= 1'b0; mem_rd_ready <= 1'b0; mem_rdata <= '0;
    end else begin
      mem_rd_ready <= rd_v1;
      mem_rdata    <= rd_d1;
      rd_v1        <= 1'b0;
      if (mem_start && !mem_rw) mem[int'(mem_addr)] = mem_wdata;
      if (mem_start && mem_rw && !noready) begin
        rd_v1 <= 1'b1;
        rd_d1 <= (mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 8'h00) | (stuck3 ? 8'h08 : 8'h00);
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_run(input int first, input int last, input logic md, input logic [DW-1:0] sd);
    req_t x;
    logic [DW-1:0] v;
    logic [31:0] a32;
    for (int p = 0; p < NPASS; p++) begin
      for (int a = first; a <= last; a++) begin
        a32 = a;
        v = md ? sd : (a32[DW-1:0] ^ sd);
        if (p == 1) v = ~v;
        x.rw = 1'b0; x.addr = AW'(a); x.wd = v;
        req_q.push_back(x);
      end
      for (int a = first; a <= last; a++) begin
        x.rw = 1'b1; x.addr = AW'(a); x.wd = '0;
        req_q.push_back(x);
      end
    end
  endtask

  task automatic push_res(input logic ps, input logic tm, input logic [15:0] er, input logic cf,
                          input logic [AW-1:0] fa, input logic [DW-1:0] fe, input logic [DW-1:0] fx,
                          input int dc);
    res_t r;
    r.pass = ps; r.tmo = tm; r.err = er; r.chkf = cf; r.fa = fa; r.fe = fe; r.fact = fx; r.dcyc = dc;
    res_q.push_back(r);
  endtask

  task automatic kick(input int first, input int last, input logic md, input logic [DW-1:0] sd,
                      output int s);
    @(posedge clk); #1;
    addr_first = AW'(first); addr_last = AW'(last); mode = md; seed = sd; start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 5000) begin @(posedge clk); #1; n++; end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL done_wait: done still %0b after %0d cycles, required 1", done, n);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reqs_left", 128'(req_q.size()), 128'd0);
    chk("results_left", 128'(res_q.size()), 128'd0);
  endtask

  task automatic wait_reqs(input int left);
    int n = 0;
    while (req_q.size() > left && n < 5000) begin @(posedge clk); #1; n++; end
    if (req_q.size() > left) begin
      vectors++; miscompares++;
      $display("FAIL req_wait: %0d requests pending, required %0d", req_q.size(), left);
    end
  endtask

  logic mon_dp;
  req_t mon_r;
  res_t mon_s;
  int   s;

  initial begin
    fork
      begin
        mon_dp = 1'b0;
        forever begin
          @(negedge clk);
          if (rst_s) begin
            chk("reset_state", 128'({mem_start, mem_rw, mem_addr, mem_wdata, busy, done, pass, timeout,
                                     err_count, first_err_addr, first_err_exp, first_err_act}), 128'd0);
            mon_dp = 1'b0;
          end else begin
            if (mem_start) begin
              if (req_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_req: rw=%0b addr=%0h, required no request", mem_rw, mem_addr);
              end else begin
                mon_r = req_q.pop_front();
                chk("req_rw", 128'(mem_rw), 128'(mon_r.rw));
                chk("req_addr", 128'(mem_addr), 128'(mon_r.addr));
                if (!mon_r.rw) chk("req_wdata", 128'(mem_wdata), 128'(mon_r.wd));
              end
            end
            if (done && !mon_dp) begin
              if (res_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_done: done rose with no run expected");
              end else begin
                mon_s = res_q.pop_front();
                chk("pass", 128'(pass), 128'(mon_s.pass));
                chk("timeout", 128'(timeout), 128'(mon_s.tmo));
                chk("err_count", 128'(err_count), 128'(mon_s.err));
                chk("busy_at_done", 128'(busy), 128'd0);
                if (mon_s.chkf) begin
                  chk("first_err_addr", 128'(first_err_addr), 128'(mon_s.fa));
                  chk("first_err_exp", 128'(first_err_exp), 128'(mon_s.fe));
                  chk("first_err_act", 128'(first_err_act), 128'(mon_s.fact));
                end
                if (mon_s.dcyc >= 0) chk("done_cycle", 128'(cyc), 128'(mon_s.dcyc));
              end
            end
            mon_dp = done;
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Ideal memory, address ^ 5A over 0..15.
    push_run(0, 15, 1'b0, 8'h5A);
    push_res(1'b1, 1'b0, 16'd0, 1'b0, '0, '0, '0, -1);
    kick(0, 15, 1'b0, 8'h5A, s);
    wait_done();

    // Bit 3 stuck high, constant 00 pattern.
    stuck3 = 1'b1;
    push_run(32'h100, 32'h103, 1'b1, 8'h00);
    push_res(1'b0, 1'b0, 16'd4, 1'b1, 21'h100, 8'h00, 8'h08, -1);
    kick(32'h100, 32'h103, 1'b1, 8'h00, s);
    wait_done();
    stuck3 = 1'b0;

    // Memory never returns read data.
    noready = 1'b1;
    push_run(0, 0, 1'b0, 8'h3C);
    push_res(1'b0, 1'b1, 16'(NPASS), 1'b0, '0, '0, '0, -1);
    kick(0, 0, 1'b0, 8'h3C, s);
    wait_done();
    noready = 1'b0;

    // Empty range: no requests, done two cycles after start is driven.
    kick(5, 4, 1'b0, 8'h00, s);
    push_res(1'b1, 1'b0, 16'd0, 1'b0, '0, '0, '0, s + 2);
    wait_done();

    // Top of address space: no wrap to 0.
    push_run(32'h1FFFFE, 32'h1FFFFF, 1'b0, 8'h33);
    push_res(1'b1, 1'b0, 16'd0, 1'b0, '0, '0, '0, -1);
    kick(32'h1FFFFE, 32'h1FFFFF, 1'b0, 8'h33, s);
    wait_done();

    // All-ones seed, constant mode; inverse pass writes 00.
    push_run(0, 1, 1'b1, 8'hFF);
    push_res(1'b1, 1'b0, 16'd0, 1'b0, '0, '0, '0, -1);
    kick(0, 1, 1'b1, 8'hFF, s);
    wait_done();

    // Stop after two writes: no third request.
    push_run(0, 1, 1'b0, 8'h11);
    req_q.delete(2);
    req_q.delete(2);
    while (req_q.size() > 2) req_q.delete(2);
    push_res(1'b1, 1'b0, 16'd0, 1'b0, '0, '0, '0, -1);
    kick(0, 15, 1'b0, 8'h11, s);
    wait_reqs(0);
    stop = 1'b1;
    wait_done();
    stop = 1'b0;

    // Reset while the second read of the top-range run is outstanding.
    push_run(32'h1FFFFE, 32'h1FFFFF, 1'b0, 8'h33);
    kick(32'h1FFFFE, 32'h1FFFFF, 1'b0, 8'h33, s);
    wait_reqs((NPASS - 1) * 4);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    req_q.delete();
    repeat (5) @(posedge clk);
    #1;
    chk("idle_after_reset", 128'({busy, done}), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
